// File: rtl/midi_out.sv
// midi_out: serial MIDI transmitter (31250-baud UART framing, 8N1, LSB first).
// Accepts one decoded channel message per valid/ready handshake and sends it
// as 1..3 MIDI bytes. Running status can optionally suppress a repeated
// status byte while the line has been idle for less than RS_TIMEOUT cycles.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   msg_valid  message fields valid
//   msg_ready  block can accept a message this cycle (IDLE only)
//   ch_message status high nibble (8..F; lower values are acknowledged and dropped)
//   chan       channel / status low nibble
//   data1      first data byte
//   data2      second data byte
//   tx         MIDI serial output, idle high
//   busy       high from acceptance until the last stop bit ends
module midi_out #(
  parameter int CLK_DIV        = 1600,
  parameter bit RUNNING_STATUS = 1'b0,
  parameter int RS_TIMEOUT     = 15000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [3:0] ch_message,
  input  logic [3:0] chan,
  input  logic [6:0] data1,
  input  logic [6:0] data2,
  output logic       tx,
  output logic       busy
);

  localparam int              IW       = (RS_TIMEOUT < 2) ? 1 : $clog2(RS_TIMEOUT + 1);
  localparam logic [15:0]     DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [IW-1:0]   RS_MAX   = IW'(RS_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Index of the final byte of a message (0 = status, 1 = data1, 2 = data2).
  function automatic logic [1:0] last_byte_idx(input logic [3:0] msg_type);
    logic [1:0] idx;
    case (msg_type)
      4'hC, 4'hD: idx = 2'd1;
      4'hF:       idx = 2'd0;
      default:    idx = 2'd2;
    endcase
    return idx;
  endfunction

  state_t          state_r, state_s;
  logic [15:0]     baud_r, baud_s;
  logic [2:0]      bit_r, bit_s;
  logic [1:0]      idx_r, idx_s;
  logic [1:0]      last_idx_r;
  logic [7:0]      status_r;
  logic [6:0]      d1_r, d2_r;
  logic [7:0]      last_status_r;
  logic            last_valid_r;
  logic [IW-1:0]   idle_cnt_r;
  logic            tx_r, tx_s;
  logic            busy_r, busy_s;
  logic            ready_r, ready_s;

  logic            accept_s;
  logic            type_ok_s;
  logic [7:0]      in_status_s;
  logic            skip_s;
  logic            baud_end_s;
  logic [7:0]      cur_byte_s;

  assign msg_ready = ready_r;
  assign tx        = tx_r;
  assign busy      = busy_r;

  // Handshake decode and running-status match for the incoming message.
  always_comb begin
    accept_s    = msg_valid && ready_r;
    type_ok_s   = ch_message[3];
    in_status_s = {ch_message, chan};
    skip_s      = RUNNING_STATUS && last_valid_r &&
                  (last_status_r == in_status_s) && (idle_cnt_r < RS_MAX);
    baud_end_s  = (baud_r == DIV_LAST);
  end

  // Byte currently on the wire, selected from the latched message fields.
  always_comb begin
    case (idx_r)
      2'd0:    cur_byte_s = status_r;
      2'd1:    cur_byte_s = {1'b0, d1_r};
      2'd2:    cur_byte_s = {1'b0, d2_r};
      default: cur_byte_s = 8'hFF;
    endcase
  end

  // Next-state logic; tx/busy/ready are computed here and registered below.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r + 16'd1;
    bit_s   = bit_r;
    idx_s   = idx_r;
    tx_s    = tx_r;
    busy_s  = busy_r;
    case (state_r)
      S_IDLE: begin
        baud_s = 16'd0;
        bit_s  = 3'd0;
        if (accept_s && type_ok_s) begin
          state_s = S_START;
          // A suppressed status byte means the frame starts at data1.
          idx_s   = skip_s ? 2'd1 : 2'd0;
          tx_s    = 1'b0;
          busy_s  = 1'b1;
        end else begin
          tx_s   = 1'b1;
          busy_s = 1'b0;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_s = S_DATA;
          baud_s  = 16'd0;
          bit_s   = 3'd0;
          tx_s    = cur_byte_s[0];
        end else begin
          tx_s = 1'b0;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_s = 16'd0;
          if (bit_r == 3'd7) begin
            state_s = S_STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s = bit_r + 3'd1;
            tx_s  = cur_byte_s[bit_s];
          end
        end else begin
          tx_s = cur_byte_s[bit_r];
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_s = 16'd0;
          if (idx_r == last_idx_r) begin
            state_s = S_IDLE;
            tx_s    = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = S_START;
            idx_s   = idx_r + 2'd1;
            tx_s    = 1'b0;
          end
        end else begin
          tx_s = 1'b1;
        end
      end
      default: begin
        state_s = S_IDLE;
        baud_s  = 16'd0;
        bit_s   = 3'd0;
        idx_s   = 2'd0;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
    ready_s = (state_s == S_IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      baud_r  <= 16'd0;
      bit_r   <= 3'd0;
      idx_r   <= 2'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      idx_r   <= idx_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
    end
  end

  // Message fields are captured on the accepting edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_r   <= 8'd0;
      d1_r       <= 7'd0;
      d2_r       <= 7'd0;
      last_idx_r <= 2'd0;
    end else if (accept_s) begin
      status_r   <= in_status_s;
      d1_r       <= data1;
      d2_r       <= data2;
      last_idx_r <= last_byte_idx(ch_message);
    end else begin
      status_r   <= status_r;
    end
  end

  // Running-status memory and the idle timer that expires it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_status_r <= 8'd0;
      last_valid_r  <= 1'b0;
      idle_cnt_r    <= '0;
    end else if (accept_s) begin
      idle_cnt_r <= '0;
      if (ch_message[3] && (ch_message != 4'hF)) begin
        last_status_r <= in_status_s;
        last_valid_r  <= 1'b1;
      end else if ((ch_message == 4'hF) && !chan[3]) begin
        // System common (F0..F7) cancels running status; realtime (F8..FF) does not.
        last_valid_r <= 1'b0;
      end else begin
        last_valid_r <= last_valid_r;
      end
    end else if (state_r == S_IDLE) begin
      if (idle_cnt_r < RS_MAX) begin
        idle_cnt_r <= idle_cnt_r + {{(IW-1){1'b0}}, 1'b1};
      end else begin
        last_valid_r <= 1'b0;
      end
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

endmodule

// File: tb/tb_midi_out.sv
// Testbench for midi_out. Two instances: unit 0 (CLK_DIV=16, no running
// status) and unit 1 (CLK_DIV=4, running status, RS_TIMEOUT=5000). A UART
// decoder per unit collects bytes; a message-level model predicts them.
module tb_midi_out;

  localparam int RS_TO = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       msg_valid_w [2];
  logic [3:0] ch_w        [2];
  logic [3:0] chan_w      [2];
  logic [6:0] d1_w        [2];
  logic [6:0] d2_w        [2];
  logic       ready_w     [2];
  logic       tx_w        [2];
  logic       busy_w      [2];

  int total_n = 0;
  int bad_n   = 0;

  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  logic [7:0] exp_q[$];
  int         last_st [2];
  longint     ref_t   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input int u);
    return (u == 0) ? 16 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int D = (g == 0) ? 16 : 4;

    midi_out #(
      .CLK_DIV(D),
      .RUNNING_STATUS(g == 1),
      .RS_TIMEOUT(RS_TO)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .msg_valid(msg_valid_w[g]),
      .msg_ready(ready_w[g]),
      .ch_message(ch_w[g]),
      .chan(chan_w[g]),
      .data1(d1_w[g]),
      .data2(d2_w[g]),
      .tx(tx_w[g]),
      .busy(busy_w[g])
    );

    logic [7:0] mb;
    bit         mab;

    // UART decoder: samples each bit in its middle, abandons on reset.
    always begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_w[g] === 1'b0) begin
        mab = 1'b0;
        mb  = 8'd0;
        for (int k = 0; k < 9; k++) begin
          for (int n = 0; n < ((k == 0) ? D + D / 2 : D); n++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) mab = 1'b1;
          end
          if (mab) break;
          if (k < 8) mb[k] = tx_w[g];
          else chk("stop_bit", 32'(tx_w[g]), 32'd1);
        end
        if (!mab) begin
          if (g == 0) rxq0.push_back(mb);
          else        rxq1.push_back(mb);
        end
      end
    end
  end

  // Message-level model: returns number of expected bytes, fills exp_q.
  function automatic int model(input int u, input logic [3:0] t, input logic [3:0] c,
                               input logic [6:0] a, input logic [6:0] b, input longint idle);
    logic [7:0] st;
    exp_q.delete();
    if (t < 4'h8) return 0;
    st = {t, c};
    if (idle >= RS_TO) last_st[u] = -1;
    if (!(u == 1 && last_st[u] == int'(st))) exp_q.push_back(st);
    if (t == 4'hC || t == 4'hD) exp_q.push_back({1'b0, a});
    else if (t != 4'hF) begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b0, b});
    end
    if (t != 4'hF) last_st[u] = int'(st);
    else if (c < 4'h8) last_st[u] = -1;
    return exp_q.size();
  endfunction

  task automatic present(input int u, input logic [3:0] t, input logic [3:0] c,
                         input logic [6:0] a, input logic [6:0] b);
    ch_w[u]        = t;
    chan_w[u]      = c;
    d1_w[u]        = a;
    d2_w[u]        = b;
    msg_valid_w[u] = 1'b1;
  endtask

  task automatic wait_accept(input int u, input bit drop, output bit ok, output longint t_acc);
    ok    = 1'b0;
    t_acc = 0;
    for (int n = 0; n < 20000; n++) begin
      if (ready_w[u] === 1'b1) begin
        @(posedge clk);
        t_acc = $time;
        #1;
        if (drop) msg_valid_w[u] = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      msg_valid_w[u] = 1'b0;
      chk("accept_timeout", 32'(ready_w[u]), 32'd1);
    end
  endtask

  task automatic check_frame(input int u, input int nb);
    int         cnt;
    int         lim;
    logic [7:0] got[$];
    @(negedge clk);
    chk("start_bit", 32'(tx_w[u]), 32'd0);
    chk("busy_rise", 32'(busy_w[u]), 32'd1);
    chk("ready_drop", 32'(ready_w[u]), 32'd0);
    cnt = 0;
    lim = nb * 10 * div_of(u) + 100;
    while (busy_w[u] === 1'b1 && cnt < lim) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", 32'(cnt), 32'(nb * 10 * div_of(u)));
    chk("ready_back", 32'(ready_w[u]), 32'd1);
    ref_t[u] = $time;
    if (u == 0) begin got = rxq0; rxq0.delete(); end
    else        begin got = rxq1; rxq1.delete(); end
    chk("byte_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("byte%0d_u%0d", i, u), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic check_invalid(input int u, input longint t_acc);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("inv_ready", 32'(ready_w[u]), 32'd1);
      chk("inv_busy", 32'(busy_w[u]), 32'd0);
      chk("inv_tx", 32'(tx_w[u]), 32'd1);
    end
    ref_t[u] = t_acc;
  endtask

  task automatic do_msg(input int u, input logic [3:0] t, input logic [3:0] c,
                        input logic [6:0] a, input logic [6:0] b, input int gap);
    bit     ok;
    longint ta;
    int     nb;
    repeat (gap) @(negedge clk);
    present(u, t, c, a, b);
    wait_accept(u, 1'b1, ok, ta);
    if (ok) begin
      nb = model(u, t, c, a, b, (ta - ref_t[u]) / 10);
      if (nb == 0) check_invalid(u, ta);
      else         check_frame(u, nb);
    end
  endtask

  bit         ok_v;
  longint     ta_v;
  int         nb_v;
  logic [3:0] rt, rc;
  logic [3:0] types1 [7] = '{4'h9, 4'h9, 4'h9, 4'hB, 4'hC, 4'hE, 4'hF};

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      msg_valid_w[u] = 1'b0;
      ch_w[u] = 4'h0; chan_w[u] = 4'h0; d1_w[u] = 7'd0; d2_w[u] = 7'd0;
      last_st[u] = -1;
    end
    #12;
    for (int u = 0; u < 2; u++) begin
      chk("rst_tx", 32'(tx_w[u]), 32'd1);
      chk("rst_busy", 32'(busy_w[u]), 32'd0);
      chk("rst_ready", 32'(ready_w[u]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("ready_after_rst", 32'(ready_w[u]), 32'd1);
      ref_t[u] = $time;
    end

    // Running status unit.
    do_msg(1, 4'h9, 4'h1, 7'h3C, 7'h64, 2);
    do_msg(1, 4'h9, 4'h1, 7'h40, 7'h5A, 10);
    do_msg(1, 4'h9, 4'h1, 7'h41, 7'h5B, 6000);
    do_msg(1, 4'hF, 4'h0, 7'h00, 7'h00, 10);
    do_msg(1, 4'h9, 4'h1, 7'h42, 7'h5C, 10);
    do_msg(1, 4'hF, 4'h8, 7'h00, 7'h00, 10);
    do_msg(1, 4'h9, 4'h1, 7'h43, 7'h5D, 10);
    for (int i = 0; i < 20; i++) begin
      rt = types1[$urandom_range(0, 6)];
      rc = (rt == 4'hF) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      do_msg(1, rt, rc, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(5200, 5800))
                                         : int'($urandom_range(0, 30)));
    end

    // Plain unit: note-on, program change, invalid type.
    do_msg(0, 4'h9, 4'h0, 7'h3C, 7'h64, 2);
    do_msg(0, 4'hC, 4'h3, 7'h05, 7'h55, 3);
    do_msg(0, 4'h5, 4'h2, 7'h11, 7'h22, 3);

    // Held msg_valid with three queued messages; intermediate fields are garbage.
    present(0, 4'hB, 4'h1, 7'h10, 7'h20);
    wait_accept(0, 1'b0, ok_v, ta_v);
    nb_v = model(0, 4'hB, 4'h1, 7'h10, 7'h20, 0);
    fork
      begin
        present(0, 4'h8, 4'hF, 7'h7F, 7'h7F);
        repeat (20) @(negedge clk);
        present(0, 4'hB, 4'h1, 7'h11, 7'h21);
      end
    join_none
    check_frame(0, nb_v);
    wait_accept(0, 1'b0, ok_v, ta_v);
    chk("hold_accept_gap", 32'(ta_v - ref_t[0]), 32'd5);
    nb_v = model(0, 4'hB, 4'h1, 7'h11, 7'h21, 0);
    fork
      begin
        present(0, 4'hA, 4'h9, 7'h01, 7'h02);
        repeat (20) @(negedge clk);
        present(0, 4'hB, 4'h1, 7'h12, 7'h22);
      end
    join_none
    check_frame(0, nb_v);
    wait_accept(0, 1'b1, ok_v, ta_v);
    chk("hold_accept_gap2", 32'(ta_v - ref_t[0]), 32'd5);
    nb_v = model(0, 4'hB, 4'h1, 7'h12, 7'h22, 0);
    check_frame(0, nb_v);

    for (int i = 0; i < 12; i++) begin
      rt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      do_msg(0, rt, 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
             7'($urandom_range(0, 127)), int'($urandom_range(0, 20)));
    end

    // Reset in the middle of the 4th data bit of 0x90.
    do_msg(1, 4'hB, 4'h2, 7'h07, 7'h7F, 3);
    present(0, 4'h9, 4'h0, 7'h3C, 7'h64);
    wait_accept(0, 1'b1, ok_v, ta_v);
    repeat (70) @(negedge clk);
    chk("mid_frame_busy", 32'(busy_w[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("async_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("async_rst_ready", 32'(ready_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    rxq0.delete();
    rxq1.delete();
    rst_n = 1'b1;
    #1;
    chk("ready_low_until_clk", 32'(ready_w[0]), 32'd0);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("ready_after_rst2", 32'(ready_w[u]), 32'd1);
      last_st[u] = -1;
      ref_t[u]   = $time;
    end
    do_msg(0, 4'hB, 4'h2, 7'h07, 7'h7F, 2);
    do_msg(1, 4'hB, 4'h2, 7'h07, 7'h7F, 2);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/midi_out.md
Name: midi_out

Overview:
- Serial MIDI transmitter, counterpart of the MIDI input receiver.
- Accepts one decoded channel message per handshake: message type nibble, channel and two 7-bit data fields.
- Emits the message as standard MIDI bytes on a 31250-baud UART line: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Used to echo or forward note and controller traffic from the synth to external gear via a GPIO pin.

Parameters:
- CLK_DIV, 1600, clk cycles per bit (50 MHz / 31250 baud); legal range 2..65535.
- RUNNING_STATUS, 0, 1 = omit a repeated status byte within the timeout window.
- RS_TIMEOUT, 15000000, idle clk cycles after which running status is forgotten (300 ms at 50 MHz).

Ports:
- clk  in  1  system clock (clk50M domain).
- rst_n  in  1  asynchronous active-low reset.
- msg_valid  in  1  message fields valid.
- msg_ready  out  1  block can accept a message this cycle.
- ch_message  in  4  status high nibble (8..F).
- chan  in  4  channel / status low nibble.
- data1  in  7  first data byte (note, CC number, LSB).
- data2  in  7  second data byte (velocity, CC value, MSB).
- tx  out  1  MIDI serial output, idle high.
- busy  out  1  high from acceptance until the last stop bit ends.

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, msg_ready=0 while asserted; state IDLE; bit/baud/byte counters 0; last_status cleared (none); idle counter 0. msg_ready rises the first clk after rst_n deasserts.
- Handshake: msg_ready=1 only in IDLE. Transfer occurs on a rising clk edge with msg_valid&&msg_ready. All input fields are latched on that edge. msg_ready drops the following cycle.
- Invalid type: ch_message<8 is acknowledged and dropped. Nothing is sent, busy stays 0, msg_ready stays 1.
- Byte count by ch_message:
  - 8,9,A,B,E: 3 bytes.
  - C,D: 2 bytes (data2 ignored).
  - F: 1 byte (status only).
- Status byte = {ch_message,chan}. Data bytes = {1'b0,dataN}.
- States: IDLE -> START -> DATA (8 bits) -> STOP -> START for the next byte, or IDLE after the last byte. Each state/bit lasts exactly CLK_DIV cycles.
- Latency: tx falls (start bit) on the first clk edge after acceptance. Successive bytes are back-to-back with no inter-byte gap. Frame = bytes*10*CLK_DIV cycles.
- busy returns 0 and msg_ready returns 1 on the same edge that ends the final stop bit.
- Running status (RUNNING_STATUS=1 only):
  - The status byte is skipped if it equals last_status and the idle counter < RS_TIMEOUT.
  - The idle counter counts IDLE cycles, saturates at RS_TIMEOUT and clears on acceptance.
  - On reaching RS_TIMEOUT, last_status is cleared.
  - ch_message 8..E updates last_status.
  - Status F0..F7 clears last_status. F8..FF leaves it unchanged.
  - With RUNNING_STATUS=0, last_status is never used.
- Simultaneous: msg_valid during busy is ignored (not latched). The source must hold msg_valid until ready.
- Reset mid-frame: tx returns to 1 immediately (async); the partial byte is abandoned and no resumption occurs.

Test Plan:
- Note-on ch0, note 60, vel 100 (0x9,0x0,0x3C,0x64) -> tx bytes 0x90,0x3C,0x64.
  - Start bit begins 1 cycle after handshake; each bit is 1600 cycles.
  - busy high for 48000 cycles; msg_ready returns 1 afterwards.
- Program change ch3, prog 5 (0xC,0x3,0x05,any) -> bytes 0xC3,0x05; 32000 cycles busy.
- RUNNING_STATUS=1, RS_TIMEOUT=5000, CLK_DIV=4:
  - Two note-ons 0x91 (60,100) then (64,90) sent 10 idle cycles apart -> second frame is 0x40,0x5A only.
  - Repeat with a 6000-cycle gap -> 0x91 is resent.
  - Insert an 0xF0 message between them -> 0x91 is resent.
- ch_message=0x5 with msg_valid pulse -> msg_ready held 1, tx stays 1, busy stays 0.
- Hold msg_valid high continuously with three queued messages -> exactly one transfer per IDLE phase; fields changed while busy are not transmitted.
- Assert rst_n=0 during the 4th data bit of 0x90 -> tx=1 and busy=0 immediately.
  - After release, a new CC 0xB2,0x07,0x7F transmits correctly, with no running status.
